// File: rtl/matrix_alu_pkg.sv
// Shared constants and types for the sequential 2x2 matrix ALU.
// Op bit positions, FSM states, per-op cycle counts, element indices, MAC modes.
package matrix_alu_pkg;

  localparam int OP_ADD = 0;
  localparam int OP_SUB = 1;
  localparam int OP_MUL = 2;

  localparam int N_ADDSUB = 4;
  localparam int N_MUL    = 8;

  // Element index = {row, col}
  localparam logic [1:0] E00 = 2'd0;
  localparam logic [1:0] E01 = 2'd1;
  localparam logic [1:0] E10 = 2'd2;
  localparam logic [1:0] E11 = 2'd3;

  typedef enum logic [1:0] {IDLE, BUSY, DONE} state_t;

  typedef enum logic [1:0] {MAC_ADD, MAC_SUB, MAC_MUL_LD, MAC_MUL_ACC} mac_mode_t;

  function automatic logic op_legal(input logic [2:0] op);
    return (op == (3'd1 << OP_ADD)) || (op == (3'd1 << OP_SUB)) || (op == (3'd1 << OP_MUL));
  endfunction

endpackage

// File: rtl/mat_elem_mac.sv
// Shared element datapath: one DW x DW multiplier and one OW-bit adder/subtractor.
// Purely combinational; carry reports only the accumulate-mode wrap.
module mat_elem_mac
  import matrix_alu_pkg::*;
#(
  parameter int DW = 8,
  parameter int OW = 16
)
(
  input  mac_mode_t     mode,
  input  logic [DW-1:0] a,
  input  logic [DW-1:0] b,
  input  logic [OW-1:0] acc,
  output logic [OW-1:0] res,
  output logic          carry
);

  logic [2*DW-1:0] prod;
  logic [OW:0]     sum;

  assign prod = (2*DW)'(a) * (2*DW)'(b);

  always_comb begin
    sum = '0;
    case (mode)
      MAC_ADD:     sum = (OW+1)'(a) + (OW+1)'(b);
      MAC_SUB:     sum = (OW+1)'(a) - (OW+1)'(b);
      MAC_MUL_LD:  sum = (OW+1)'(prod);
      MAC_MUL_ACC: sum = {1'b0, acc} + (OW+1)'(prod);
      default:     sum = '0;
    endcase
  end

  // Bit OW of a subtract is a borrow, not an overflow, so only accumulate reports it.
  assign res   = sum[OW-1:0];
  assign carry = (mode == MAC_MUL_ACC) && sum[OW];

endmodule

// File: rtl/matrix_alu_seq.sv
// Sequential 2x2 matrix add/sub/mult over one shared MAC; out_valid N+1 cycles after accept (4/8 BUSY cycles).
// One op in flight: in_ready only in IDLE, DONE holds results until out_ready. MATRIX_ALU_SEQ_PERF_EN adds perf counters.
module matrix_alu_seq
  import matrix_alu_pkg::*;
#(
  parameter int DW = 8,
  parameter int OW = 16
)
(
  input  logic          clk,
  input  logic          rst,
  input  logic          in_valid,
  output logic          in_ready,
  input  logic [2:0]    op,
  input  logic [DW-1:0] a00,
  input  logic [DW-1:0] a01,
  input  logic [DW-1:0] a10,
  input  logic [DW-1:0] a11,
  input  logic [DW-1:0] b00,
  input  logic [DW-1:0] b01,
  input  logic [DW-1:0] b10,
  input  logic [DW-1:0] b11,
  output logic          out_valid,
  input  logic          out_ready,
  output logic [OW-1:0] y00,
  output logic [OW-1:0] y01,
  output logic [OW-1:0] y10,
  output logic [OW-1:0] y11,
  output logic          ovf,
  output logic          err
`ifdef MATRIX_ALU_SEQ_PERF_EN
  ,
  output logic [15:0]   perf_ops,
  output logic [31:0]   perf_busy
`endif
);

  state_t        state;
  logic [2:0]    k;
  logic          is_mul;
  logic          is_sub;
  logic [DW-1:0] a_r [4];
  logic [DW-1:0] b_r [4];
  logic [OW-1:0] acc;
  logic [OW-1:0] y_r [4];

  logic [1:0]    e;
  logic [1:0]    ai;
  logic [1:0]    bi;
  logic          last_k;
  mac_mode_t     mode;
  logic [OW-1:0] mac_res;
  logic          mac_carry;

  // Multiply walks k as {element, term}: term t picks A column t and B row t.
  always_comb begin
    e      = is_mul ? k[2:1] : k[1:0];
    ai     = is_mul ? {e[1], k[0]} : e;
    bi     = is_mul ? {k[0], e[0]} : e;
    mode   = is_mul ? (k[0] ? MAC_MUL_ACC : MAC_MUL_LD) : (is_sub ? MAC_SUB : MAC_ADD);
    last_k = (k == (is_mul ? 3'(N_MUL - 1) : 3'(N_ADDSUB - 1)));
  end

  mat_elem_mac #(.DW(DW), .OW(OW)) u_mac (
    .mode  (mode),
    .a     (a_r[ai]),
    .b     (b_r[bi]),
    .acc   (acc),
    .res   (mac_res),
    .carry (mac_carry)
  );

  always_ff @(posedge clk) begin
    if (rst) begin
      state     <= IDLE;
      in_ready  <= 1'b1;
      out_valid <= 1'b0;
      ovf       <= 1'b0;
      err       <= 1'b0;
      k         <= '0;
      acc       <= '0;
      is_mul    <= 1'b0;
      is_sub    <= 1'b0;
      for (int i = 0; i < 4; i++) begin
        y_r[i] <= '0;
        a_r[i] <= '0;
        b_r[i] <= '0;
      end
    end else begin
      case (state)
        IDLE: begin
          if (in_valid && in_ready) begin
            a_r[E00] <= a00;
            a_r[E01] <= a01;
            a_r[E10] <= a10;
            a_r[E11] <= a11;
            b_r[E00] <= b00;
            b_r[E01] <= b01;
            b_r[E10] <= b10;
            b_r[E11] <= b11;
            is_mul   <= op[OP_MUL];
            is_sub   <= op[OP_SUB];
            for (int i = 0; i < 4; i++) y_r[i] <= '0;
            ovf      <= 1'b0;
            k        <= '0;
            in_ready <= 1'b0;
            if (op_legal(op)) begin
              err   <= 1'b0;
              state <= BUSY;
            end else begin
              err       <= 1'b1;
              out_valid <= 1'b1;
              state     <= DONE;
            end
          end
        end
        BUSY: begin
          if (mode == MAC_MUL_LD) begin
            acc <= mac_res;
          end else begin
            y_r[e] <= mac_res;
          end
          if (mac_carry) ovf <= 1'b1;
          if (last_k) begin
            k         <= '0;
            out_valid <= 1'b1;
            state     <= DONE;
          end else begin
            k <= k + 3'd1;
          end
        end
        DONE: begin
          if (out_ready) begin
            out_valid <= 1'b0;
            in_ready  <= 1'b1;
            state     <= IDLE;
          end
        end
        default: begin
          state     <= IDLE;
          in_ready  <= 1'b1;
          out_valid <= 1'b0;
        end
      endcase
    end
  end

  assign y00 = y_r[E00];
  assign y01 = y_r[E01];
  assign y10 = y_r[E10];
  assign y11 = y_r[E11];

`ifdef MATRIX_ALU_SEQ_PERF_EN
  always_ff @(posedge clk) begin
    if (rst) begin
      perf_ops  <= '0;
      perf_busy <= '0;
    end else begin
      if (out_valid && out_ready) perf_ops <= perf_ops + 16'd1;
      if (state == BUSY)          perf_busy <= perf_busy + 32'd1;
    end
  end
`endif

endmodule

// File: tb/tb_matrix_alu_seq.sv
// Self-checking bench for matrix_alu_seq: directed plan cases plus randomized ops vs a behavioural model.
module tb_matrix_alu_seq;

  typedef logic [3:0][7:0]  mat8_t;
  typedef logic [3:0][15:0] mat16_t;

  logic        clk = 1'b0;
  logic        rst;
  logic        in_valid;
  logic        in_ready;
  logic [2:0]  op;
  logic [7:0]  a00, a01, a10, a11, b00, b01, b10, b11;
  logic        out_valid;
  logic        out_ready;
  logic [15:0] y00, y01, y10, y11;
  logic        ovf;
  logic        err;
`ifdef MATRIX_ALU_SEQ_PERF_EN
  logic [15:0] perf_ops;
  logic [31:0] perf_busy;
`endif

  int tests = 0;
  int fails = 0;
  int exp_ops = 0;
  int exp_busy = 0;
  int pend_busy = 0;

  always #5 clk = ~clk;

  matrix_alu_seq #(.DW(8), .OW(16)) dut (
    .clk(clk), .rst(rst), .in_valid(in_valid), .in_ready(in_ready), .op(op),
    .a00(a00), .a01(a01), .a10(a10), .a11(a11),
    .b00(b00), .b01(b01), .b10(b10), .b11(b11),
    .out_valid(out_valid), .out_ready(out_ready),
    .y00(y00), .y01(y01), .y10(y10), .y11(y11),
    .ovf(ovf), .err(err)
`ifdef MATRIX_ALU_SEQ_PERF_EN
    , .perf_ops(perf_ops), .perf_busy(perf_busy)
`endif
  );

  // Reference: matrix semantics straight from the op definitions.
  function automatic void model(input mat8_t a, input mat8_t b, input logic [2:0] o,
                                output mat16_t y, output logic eovf, output logic eerr, output int lat);
    int s;
    y = '0; eovf = 1'b0; eerr = 1'b0;
    if (o == 3'b001) begin
      for (int i = 0; i < 4; i++) y[i] = 16'(int'(a[i]) + int'(b[i]));
      lat = 5;
    end else if (o == 3'b010) begin
      for (int i = 0; i < 4; i++) y[i] = 16'(int'(a[i]) - int'(b[i]));
      lat = 5;
    end else if (o == 3'b100) begin
      for (int r = 0; r < 2; r++)
        for (int c = 0; c < 2; c++) begin
          s = int'(a[2*r]) * int'(b[c]) + int'(a[2*r+1]) * int'(b[2+c]);
          y[2*r+c] = 16'(s);
          if (s > 65535) eovf = 1'b1;
        end
      lat = 9;
    end else begin
      eerr = 1'b1;
      lat = 1;
    end
  endfunction

  function automatic mat16_t got_y();
    return {y11, y10, y01, y00};
  endfunction

  task automatic drive(input mat8_t a, input mat8_t b, input logic [2:0] o);
    a00 = a[0]; a01 = a[1]; a10 = a[2]; a11 = a[3];
    b00 = b[0]; b01 = b[1]; b10 = b[2]; b11 = b[3];
    op = o;
  endtask

  // Issues one op from IDLE and waits (bounded) for out_valid; lat counts cycles after the accept edge.
  task automatic exec(input mat8_t a, input mat8_t b, input logic [2:0] o,
                      output mat16_t ey, output logic eovf, output logic eerr, output int elat,
                      output int lat);
    model(a, b, o, ey, eovf, eerr, elat);
    pend_busy = elat - 1;
    drive(a, b, o);
    in_valid = 1'b1;
    @(posedge clk); #1;
    in_valid = 1'b0;
    lat = 1;
    while (!out_valid && lat < 40) begin
      @(posedge clk); #1;
      lat++;
    end
  endtask

  task automatic complete();
    out_ready = 1'b1;
    @(posedge clk); #1;
    exp_ops++;
    exp_busy += pend_busy;
  endtask

  task automatic test_reset();
    rst = 1'b1; in_valid = 1'b0; out_ready = 1'b0;
    drive('0, '0, 3'b000);
    repeat (3) @(posedge clk);
    #1 rst = 1'b0;
    @(posedge clk); #1;
    tests++;
    if (in_ready !== 1'b1 || out_valid !== 1'b0 || ovf !== 1'b0 || err !== 1'b0) begin
      fails++;
      $display("FAIL reset_ctrl: in_ready=%b out_valid=%b ovf=%b err=%b, want 1 0 0 0", in_ready, out_valid, ovf, err);
    end
    tests++;
    if (got_y() !== '0) begin
      fails++;
      $display("FAIL reset_y: got %h want 0", got_y());
    end
`ifdef MATRIX_ALU_SEQ_PERF_EN
    tests++;
    if (perf_ops !== 16'd0 || perf_busy !== 32'd0) begin
      fails++;
      $display("FAIL reset_perf: ops=%0d busy=%0d want 0 0", perf_ops, perf_busy);
    end
`endif
    out_ready = 1'b1;
  endtask

  task automatic test_add();
    mat16_t ey; logic eovf, eerr; int elat, lat;
    exec({8'd255, 8'd30, 8'd20, 8'd10}, {8'd255, 8'd3, 8'd2, 8'd1}, 3'b001, ey, eovf, eerr, elat, lat);
    tests++;
    if (lat !== elat) begin fails++; $display("FAIL add_latency: got %0d want %0d", lat, elat); end
    tests++;
    if (got_y() !== {16'd510, 16'd33, 16'd22, 16'd11} || got_y() !== ey) begin
      fails++; $display("FAIL add_y: got %h want %h", got_y(), ey);
    end
    tests++;
    if (ovf !== 1'b0 || err !== 1'b0) begin fails++; $display("FAIL add_flags: ovf=%b err=%b want 0 0", ovf, err); end
    complete();
    tests++;
    if (out_valid !== 1'b0 || in_ready !== 1'b1) begin
      fails++; $display("FAIL add_return_idle: out_valid=%b in_ready=%b want 0 1", out_valid, in_ready);
    end
  endtask

  task automatic test_sub();
    mat16_t ey; logic eovf, eerr; int elat, lat;
    exec({8'd200, 8'd0, 8'd3, 8'd5}, {8'd200, 8'd1, 8'd5, 8'd2}, 3'b010, ey, eovf, eerr, elat, lat);
    tests++;
    if (lat !== 5) begin fails++; $display("FAIL sub_latency: got %0d want 5", lat); end
    tests++;
    if (got_y() !== {16'h0000, 16'hFFFF, 16'hFFFE, 16'h0003} || got_y() !== ey) begin
      fails++; $display("FAIL sub_y: got %h want %h", got_y(), ey);
    end
    tests++;
    if (ovf !== 1'b0 || err !== 1'b0) begin fails++; $display("FAIL sub_flags: ovf=%b err=%b want 0 0", ovf, err); end
    complete();
  endtask

  task automatic test_mult();
    mat16_t ey; logic eovf, eerr; int elat, lat;
    exec({8'd4, 8'd3, 8'd2, 8'd1}, {8'd8, 8'd7, 8'd6, 8'd5}, 3'b100, ey, eovf, eerr, elat, lat);
    tests++;
    if (lat !== 9) begin fails++; $display("FAIL mult_latency: got %0d want 9", lat); end
    tests++;
    if (got_y() !== {16'd50, 16'd43, 16'd22, 16'd19} || got_y() !== ey) begin
      fails++; $display("FAIL mult_y: got %h want %h", got_y(), ey);
    end
    tests++;
    if (ovf !== 1'b0) begin fails++; $display("FAIL mult_ovf_clear: got %b want 0", ovf); end
    complete();
    exec({4{8'd255}}, {4{8'd255}}, 3'b100, ey, eovf, eerr, elat, lat);
    tests++;
    if (got_y() !== {4{16'd64514}} || got_y() !== ey) begin
      fails++; $display("FAIL mult_wrap_y: got %h want %h", got_y(), ey);
    end
    tests++;
    if (ovf !== 1'b1 || err !== 1'b0) begin fails++; $display("FAIL mult_wrap_flags: ovf=%b err=%b want 1 0", ovf, err); end
    complete();
  endtask

  task automatic test_illegal();
    mat16_t ey; logic eovf, eerr; int elat, lat;
    logic [2:0] bad [2];
    bad[0] = 3'b000; bad[1] = 3'b011;
    for (int i = 0; i < 2; i++) begin
      exec({4{8'd9}}, {4{8'd7}}, bad[i], ey, eovf, eerr, elat, lat);
      tests++;
      if (lat !== 1) begin fails++; $display("FAIL illegal_latency op=%b: got %0d want 1", bad[i], lat); end
      tests++;
      if (got_y() !== '0 || err !== 1'b1 || ovf !== 1'b0) begin
        fails++; $display("FAIL illegal_out op=%b: y=%h err=%b ovf=%b want 0 1 0", bad[i], got_y(), err, ovf);
      end
      complete();
    end
  endtask

  task automatic test_ignore_busy();
    mat16_t ey; logic eovf, eerr; int elat, lat;
    logic rdy_seen;
    model({8'd4, 8'd3, 8'd2, 8'd1}, {8'd8, 8'd7, 8'd6, 8'd5}, 3'b100, ey, eovf, eerr, elat);
    pend_busy = elat - 1;
    drive({8'd4, 8'd3, 8'd2, 8'd1}, {8'd8, 8'd7, 8'd6, 8'd5}, 3'b100);
    in_valid = 1'b1;
    @(posedge clk); #1;
    in_valid = 1'b0;
    lat = 1;
    rdy_seen = 1'b0;
    while (!out_valid && lat < 40) begin
      if (lat == 3) begin
        drive({4{8'd99}}, {4{8'd1}}, 3'b001);
        in_valid = 1'b1;
      end
      if (in_ready) rdy_seen = 1'b1;
      @(posedge clk); #1;
      lat++;
    end
    in_valid = 1'b0;
    tests++;
    if (rdy_seen !== 1'b0) begin fails++; $display("FAIL busy_in_ready: got 1 want 0"); end
    tests++;
    if (lat !== 9 || got_y() !== ey) begin
      fails++; $display("FAIL busy_ignore: lat=%0d y=%h want %0d %h", lat, got_y(), elat, ey);
    end
    complete();
    repeat (3) @(posedge clk);
    #1;
    tests++;
    if (out_valid !== 1'b0 || in_ready !== 1'b1) begin
      fails++; $display("FAIL busy_not_queued: out_valid=%b in_ready=%b want 0 1", out_valid, in_ready);
    end
  endtask

  task automatic test_backpressure();
    mat16_t ey, snap; logic eovf, eerr; int elat, lat; int bad;
    out_ready = 1'b0;
    exec({8'd17, 8'd33, 8'd250, 8'd7}, {8'd3, 8'd200, 8'd9, 8'd100}, 3'b010, ey, eovf, eerr, elat, lat);
    snap = got_y();
    bad = 0;
    for (int c = 0; c < 10; c++) begin
      @(posedge clk); #1;
      if (out_valid !== 1'b1 || in_ready !== 1'b0 || got_y() !== snap || err !== 1'b0) bad++;
    end
    tests++;
    if (bad != 0) begin fails++; $display("FAIL bp_stall: %0d unstable cycles, want 0", bad); end
    tests++;
    if (snap !== ey) begin fails++; $display("FAIL bp_y: got %h want %h", snap, ey); end
    complete();
    tests++;
    if (out_valid !== 1'b0 || in_ready !== 1'b1) begin
      fails++; $display("FAIL bp_release: out_valid=%b in_ready=%b want 0 1", out_valid, in_ready);
    end
  endtask

  task automatic test_back_to_back();
    mat16_t ey; logic eovf, eerr; int elat, lat;
    exec({8'd11, 8'd12, 8'd13, 8'd14}, {8'd21, 8'd22, 8'd23, 8'd24}, 3'b100, ey, eovf, eerr, elat, lat);
    tests++;
    if (lat !== elat || got_y() !== ey || ovf !== eovf) begin
      fails++; $display("FAIL b2b: lat=%0d y=%h ovf=%b want %0d %h %b", lat, got_y(), ovf, elat, ey, eovf);
    end
    complete();
  endtask

  task automatic test_reset_abort();
    mat16_t ey; logic eovf, eerr; int elat, lat;
    drive({8'd4, 8'd3, 8'd2, 8'd1}, {8'd8, 8'd7, 8'd6, 8'd5}, 3'b100);
    in_valid = 1'b1;
    @(posedge clk); #1;
    in_valid = 1'b0;
    repeat (3) @(posedge clk);
    #1;
    tests++;
    if (y00 !== 16'd19 || y01 !== 16'd0 || out_valid !== 1'b0) begin
      fails++; $display("FAIL abort_partial: y00=%0d y01=%0d out_valid=%b want 19 0 0", y00, y01, out_valid);
    end
    rst = 1'b1;
    @(posedge clk); #1;
    rst = 1'b0;
    exp_ops = 0; exp_busy = 0;
    tests++;
    if (out_valid !== 1'b0 || in_ready !== 1'b1 || got_y() !== '0 || ovf !== 1'b0 || err !== 1'b0) begin
      fails++; $display("FAIL abort_reset: out_valid=%b in_ready=%b y=%h ovf=%b err=%b want 0 1 0 0 0",
                        out_valid, in_ready, got_y(), ovf, err);
    end
    exec({8'd1, 8'd128, 8'd64, 8'd200}, {8'd2, 8'd128, 8'd100, 8'd60}, 3'b001, ey, eovf, eerr, elat, lat);
    tests++;
    if (lat !== 5 || got_y() !== ey) begin
      fails++; $display("FAIL abort_fresh_add: lat=%0d y=%h want 5 %h", lat, got_y(), ey);
    end
    complete();
`ifdef MATRIX_ALU_SEQ_PERF_EN
    tests++;
    if (perf_ops !== 16'(exp_ops) || perf_busy !== 32'(exp_busy)) begin
      fails++; $display("FAIL abort_perf: ops=%0d busy=%0d want %0d %0d", perf_ops, perf_busy, exp_ops, exp_busy);
    end
`endif
  endtask

  task automatic test_random();
    mat16_t ey; logic eovf, eerr; int elat, lat;
    mat8_t a, b; logic [2:0] o; int sel;
    logic [2:0] bad [5];
    bad[0] = 3'b000; bad[1] = 3'b011; bad[2] = 3'b101; bad[3] = 3'b110; bad[4] = 3'b111;
    for (int it = 0; it < 30; it++) begin
      for (int i = 0; i < 4; i++) begin
        a[i] = 8'($urandom);
        b[i] = 8'($urandom);
      end
      sel = $urandom_range(0, 9);
      o = (sel < 3) ? 3'b001 : (sel < 6) ? 3'b010 : (sel < 9) ? 3'b100 : bad[$urandom_range(0, 4)];
      out_ready = 1'($urandom_range(0, 1));
      exec(a, b, o, ey, eovf, eerr, elat, lat);
      tests++;
      if (lat !== elat) begin fails++; $display("FAIL rnd%0d_latency op=%b: got %0d want %0d", it, o, lat, elat); end
      tests++;
      if (got_y() !== ey) begin fails++; $display("FAIL rnd%0d_y op=%b: got %h want %h", it, o, got_y(), ey); end
      tests++;
      if (ovf !== eovf || err !== eerr) begin
        fails++; $display("FAIL rnd%0d_flags op=%b: ovf=%b err=%b want %b %b", it, o, ovf, err, eovf, eerr);
      end
      if (!out_ready) repeat ($urandom_range(1, 4)) @(posedge clk);
      #0;
      complete();
    end
`ifdef MATRIX_ALU_SEQ_PERF_EN
    tests++;
    if (perf_ops !== 16'(exp_ops) || perf_busy !== 32'(exp_busy)) begin
      fails++; $display("FAIL rnd_perf: ops=%0d busy=%0d want %0d %0d", perf_ops, perf_busy, exp_ops, exp_busy);
    end
`endif
  endtask

  initial begin
    test_reset();
    test_add();
    test_sub();
    test_mult();
    test_illegal();
    test_ignore_busy();
    test_backpressure();
    test_back_to_back();
    test_reset_abort();
    test_random();
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule

// File: doc/matrix_alu_seq.md
Name: matrix_alu_seq

Overview:
- Sequential, area-reduced controller for the team's 2x2 8-bit matrix ALU (add / subtract / multiply).
- Time-multiplexes one 8x8 multiplier and one 16-bit adder across all matrix elements instead of instantiating 8 multipliers and 12 adders.
- Accepts a full operand set and one-hot op over a valid/ready handshake, sequences element computation with an FSM, and presents registered 16-bit results with a valid/ready handshake.
- Sits between the command source and the result consumer in place of the combinational matrix ALU top.

Parameters:
- DW, 8, operand element width.
- OW, 16, result element width; must be at least 2*DW.

Ports:
- clk  in  1  rising-edge clock.
- rst  in  1  synchronous, active-high reset.
- in_valid  in  1  operand set and op valid.
- in_ready  out  1  block can accept; high only in IDLE.
- op  in  3  one-hot: [0]=add, [1]=sub, [2]=mult.
- a00, a01, a10, a11  in  DW each  matrix A elements.
- b00, b01, b10, b11  in  DW each  matrix B elements.
- out_valid  out  1  results valid.
- out_ready  in  1  consumer accepts results.
- y00, y01, y10, y11  out  OW each  result elements.
- ovf  out  1  some multiply element result exceeded OW bits (sticky per operation).
- err  out  1  illegal op (not exactly one bit set).

Behaviour:
- Reset values:
  - state=IDLE, in_ready=1, out_valid=0, y**=0, ovf=0, err=0.
  - Internal counter=0, accumulator=0.
- Accept:
  - Occurs when in_valid && in_ready.
  - Latches all 8 operands and op; clears y**, ovf and err.
  - Moves to BUSY, or straight to DONE if op is illegal.
- FSM states: IDLE -> BUSY -> DONE -> IDLE.
  - BUSY runs N cycles, k = 0..N-1.
  - DONE holds out_valid=1 with stable y**, ovf and err until out_ready.
  - On out_valid && out_ready, return to IDLE next cycle.
- Add (N=4):
  - Cycle k computes element e=k in order 00, 01, 10, 11.
  - y_e = zero-extended a_e + b_e; max 510.
- Sub (N=4):
  - Same element order.
  - y_e = OW-bit two's-complement of (zero-extended a_e − zero-extended b_e); e.g. 3−5 = 16'hFFFE.
- Mult (N=8):
  - Element e=k>>1, term t=k&1.
  - Terms:
    - y00 = a00*b00 + a01*b10
    - y01 = a00*b01 + a01*b11
    - y10 = a10*b00 + a11*b10
    - y11 = a10*b01 + a11*b11
  - t=0 loads the accumulator with the product; t=1 adds the product and writes y_e.
  - Sums are modulo 2^OW; the carry out of the OW-bit add sets ovf, which stays set until the next accept.
- Latency:
  - Accept at cycle 0; out_valid rises at cycle N+1 (add/sub 5, mult 9).
  - Illegal op: out_valid at cycle 1, y**=0, err=1.
- Throughput:
  - One operation in flight.
  - in_ready=0 in BUSY and DONE; in_valid there is ignored and not queued.
  - Minimum spacing between accepts is N+2 cycles.
- out_ready held high early: completes in the first DONE cycle.
- out_ready low: DONE stalls indefinitely; outputs are frozen.
- rst mid-BUSY or mid-DONE: abort; all outputs return to reset values next cycle; partial results are discarded.
- y** registers update only in BUSY on their element's write cycle; unwritten elements read 0 until written.

Optional Feature:
- Macro: MATRIX_ALU_SEQ_PERF_EN.
- Defined:
  - Adds output perf_ops (16 bits), counting completed output handshakes; wraps 16'hFFFF -> 0; reset to 0.
  - Adds output perf_busy (32 bits), counting cycles spent in BUSY; wraps; reset to 0.
- Undefined: neither port nor counter exists; all other behaviour is identical.

Decomposition:
- Package matrix_alu_pkg:
  - op bit indices OP_ADD=0, OP_SUB=1, OP_MUL=2.
  - FSM state enum IDLE/BUSY/DONE.
  - Cycle counts N_ADDSUB=4, N_MUL=8.
  - Element index constants E00..E11.
- Sub-module mat_elem_mac:
  - Combinational, one DW x DW multiplier plus one OW-bit add/sub with carry out.
  - Mode select: add, sub, mul-load, mul-accumulate.
- matrix_alu_seq holds the FSM, counter, operand/accumulator/result registers and element muxing.

Test Plan:
- Add: A={10,20,30,255}, B={1,2,3,255}, op=001 -> out_valid at cycle 5, y={11,22,33,510}, ovf=0, err=0.
- Sub: A={5,3,0,200}, B={2,5,1,200}, op=010 -> y={3,16'hFFFE,16'hFFFF,0} at cycle 5.
- Mult: A={1,2,3,4}, B={5,6,7,8}, op=100 -> y={19,22,43,50} at cycle 9. Then all elements 255 -> y=130050 mod 65536 = 64514 each, ovf=1.
- Illegal op 000, then 011 -> out_valid at cycle 1, y=0, err=1. in_valid pulsed during BUSY of a legal op is ignored (in_ready=0).
- Backpressure: out_ready=0 for 10 cycles after out_valid -> outputs stable and in_ready=0. Then out_ready=1 -> IDLE next cycle; back-to-back accept succeeds.
- Reset at BUSY cycle k=3 of mult -> next cycle out_valid=0, y=0, in_ready=1. A fresh add then gives correct results. With MATRIX_ALU_SEQ_PERF_EN, perf_ops excludes the aborted operation.
